// File: rtl/tmr_pkg.sv
// Shared types and constants for the countdown timer: FSM state encoding,
// field limits and the preset clamp helper.
package tmr_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        RUN     = 3'd2,
        PAUSE   = 3'd3,
        EXPIRED = 3'd4
    } tmr_state_e;

    localparam int SEC_MAX     = 59;
    localparam int MIN_MAX     = 59;
    localparam int ALARM_TICKS = 10;

    function automatic logic [7:0] clamp8(input logic [7:0] v, input logic [7:0] mx);
        return (v > mx) ? mx : v;
    endfunction

endpackage

// File: rtl/dn_count_unit.sv
// One mod-(MAX+1) down counter field with load, clear and decrement enable;
// borrow_out flags a decrement taken while the field is already at zero.
module dn_count_unit #(
    parameter int MAX = 59
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       ld,
    input  logic [7:0] ld_val,
    input  logic       dec,
    output logic [7:0] cnt,
    output logic       borrow_out
);

    localparam logic [7:0] MAX8 = 8'(MAX);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (ld)
            cnt_d = ld_val;
        else if (dec)
            cnt_d = (cnt_q == 8'd0) ? MAX8 : cnt_q - 8'd1;
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt        = cnt_q;
    assign borrow_out = dec && (cnt_q == 8'd0);

endmodule

// File: rtl/tmr_countdown.sv
// Countdown timer core: HH:MM:SS preset, 1 Hz decrement with cascading borrow,
// one-cycle done pulse and a tick-timed alarm window after expiry.
module tmr_countdown
    import tmr_pkg::*;
#(
    parameter int MAX_HR      = 23,
    parameter int ALARM_TICKS = tmr_pkg::ALARM_TICKS
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       load,
    input  logic [7:0] set_hr,
    input  logic [7:0] set_min,
    input  logic [7:0] set_sec,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    output logic [7:0] hrs,
    output logic [7:0] mins,
    output logic [7:0] secs,
    output logic       running,
    output logic       done,
    output logic       alarm
);

    localparam logic [7:0] HR_MAX8    = 8'(MAX_HR);
    localparam logic [7:0] ALARM_LAST = 8'(ALARM_TICKS);

    tmr_state_e state_q, state_d;
    logic       done_q, done_d;
    logic       alarm_q, alarm_d;
    logic       running_q, running_d;
    logic [7:0] alarm_cnt_q, alarm_cnt_d;

    logic       cnt_clr, cnt_ld, sec_dec;
    logic       sec_borrow, min_borrow, hr_borrow;
    logic [7:0] ld_hr, ld_min, ld_sec;
    logic       at_one;

    assign ld_hr  = clamp8(set_hr, HR_MAX8);
    assign ld_min = clamp8(set_min, 8'(MIN_MAX));
    assign ld_sec = clamp8(set_sec, 8'(SEC_MAX));
    assign at_one = (hrs == 8'd0) && (mins == 8'd0) && (secs == 8'd1);

    always_comb begin
        state_d     = state_q;
        done_d      = 1'b0;
        alarm_d     = alarm_q;
        alarm_cnt_d = alarm_cnt_q;
        cnt_clr     = 1'b0;
        cnt_ld      = 1'b0;
        sec_dec     = 1'b0;
        if (clear) begin
            state_d     = IDLE;
            cnt_clr     = 1'b1;
            alarm_d     = 1'b0;
            alarm_cnt_d = '0;
        end else if (load && (state_q == IDLE || state_q == ARMED || state_q == EXPIRED)) begin
            cnt_ld      = 1'b1;
            state_d     = (ld_hr != 8'd0 || ld_min != 8'd0 || ld_sec != 8'd0) ? ARMED : IDLE;
            alarm_d     = 1'b0;
            alarm_cnt_d = '0;
        end else if (pause && state_q == RUN) begin
            state_d = PAUSE;
        end else if (start && (state_q == ARMED || state_q == PAUSE)) begin
            state_d = RUN;
        end else if (tick_1hz) begin
            if (state_q == RUN) begin
                sec_dec = 1'b1;
                if (at_one) begin
                    state_d     = EXPIRED;
                    done_d      = 1'b1;
                    alarm_d     = 1'b1;
                    alarm_cnt_d = '0;
                end
            end else if (state_q == EXPIRED) begin
                if (alarm_cnt_q + 8'd1 >= ALARM_LAST) begin
                    state_d     = IDLE;
                    alarm_d     = 1'b0;
                    alarm_cnt_d = '0;
                end else begin
                    alarm_cnt_d = alarm_cnt_q + 8'd1;
                end
            end
        end
        running_d = (state_d == RUN);
    end

    // An hours borrow would mean underflow past 00:00:00; park in IDLE if it ever shows.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            done_q      <= 1'b0;
            alarm_q     <= 1'b0;
            running_q   <= 1'b0;
            alarm_cnt_q <= '0;
        end else begin
            state_q     <= hr_borrow ? IDLE : state_d;
            done_q      <= done_d;
            alarm_q     <= alarm_d;
            running_q   <= running_d && !hr_borrow;
            alarm_cnt_q <= alarm_cnt_d;
        end
    end

    dn_count_unit #(.MAX(SEC_MAX)) u_sec (
        .CLK(CLK), .rst_n(rst_n), .clr(cnt_clr), .ld(cnt_ld), .ld_val(ld_sec),
        .dec(sec_dec), .cnt(secs), .borrow_out(sec_borrow)
    );

    dn_count_unit #(.MAX(MIN_MAX)) u_min (
        .CLK(CLK), .rst_n(rst_n), .clr(cnt_clr), .ld(cnt_ld), .ld_val(ld_min),
        .dec(sec_borrow), .cnt(mins), .borrow_out(min_borrow)
    );

    dn_count_unit #(.MAX(MAX_HR)) u_hr (
        .CLK(CLK), .rst_n(rst_n), .clr(cnt_clr), .ld(cnt_ld), .ld_val(ld_hr),
        .dec(min_borrow), .cnt(hrs), .borrow_out(hr_borrow)
    );

    assign running = running_q;
    assign done    = done_q;
    assign alarm   = alarm_q;

endmodule

// File: tb/tb_tmr_countdown.sv
// Scoreboard bench for tmr_countdown: each driven cycle pushes its expected
// outputs, which are popped and compared one cycle later.
module tb_tmr_countdown;

    logic       CLK = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_1hz = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0, clear = 1'b0;
    logic [7:0] set_hr = '0, set_min = '0, set_sec = '0;
    logic [7:0] hrs, mins, secs;
    logic       running, done, alarm;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      tag;
        logic [7:0] h, m, s;
        logic       run, dn, al;
    } exp_t;

    exp_t sb_q[$];

    tmr_countdown #(.MAX_HR(23), .ALARM_TICKS(10)) dut (
        .CLK(CLK), .rst_n(rst_n), .tick_1hz(tick_1hz), .load(load),
        .set_hr(set_hr), .set_min(set_min), .set_sec(set_sec),
        .start(start), .pause(pause), .clear(clear),
        .hrs(hrs), .mins(mins), .secs(secs),
        .running(running), .done(done), .alarm(alarm)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of commands, queue the expectation, compare after the edge.
    task automatic cyc(input string tag, input logic ld, input logic st, input logic ps,
                       input logic cl, input logic tk,
                       input logic [7:0] sh, input logic [7:0] sm, input logic [7:0] ss,
                       input logic [7:0] eh, input logic [7:0] em, input logic [7:0] es,
                       input logic er, input logic ed, input logic ea);
        exp_t e;
        load = ld; start = st; pause = ps; clear = cl; tick_1hz = tk;
        set_hr = sh; set_min = sm; set_sec = ss;
        e.tag = tag; e.h = eh; e.m = em; e.s = es; e.run = er; e.dn = ed; e.al = ea;
        sb_q.push_back(e);
        @(posedge CLK);
        #1;
        load = 0; start = 0; pause = 0; clear = 0; tick_1hz = 0;
        e = sb_q.pop_front();
        chk({e.tag, ".hrs"}, hrs, e.h);
        chk({e.tag, ".mins"}, mins, e.m);
        chk({e.tag, ".secs"}, secs, e.s);
        chk({e.tag, ".running"}, {7'd0, running}, {7'd0, e.run});
        chk({e.tag, ".done"}, {7'd0, done}, {7'd0, e.dn});
        chk({e.tag, ".alarm"}, {7'd0, alarm}, {7'd0, e.al});
    endtask

    task automatic idle(input string tag, input logic [7:0] eh, input logic [7:0] em,
                        input logic [7:0] es, input logic er, input logic ea);
        cyc(tag, 0,0,0,0,0, 0,0,0, eh,em,es, er,1'b0,ea);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".hrs"}, hrs, 8'd0);
        chk({tag, ".mins"}, mins, 8'd0);
        chk({tag, ".secs"}, secs, 8'd0);
        chk({tag, ".flags"}, {5'd0, running, done, alarm}, 8'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        chk_zero("reset");
        @(negedge CLK); @(negedge CLK);
        rst_n = 1'b1;
        @(posedge CLK); #1;

        // 00:00:03 countdown to expiry
        cyc("ld3",   1,0,0,0,0, 0,0,3,   0,0,3, 0,0,0);
        cyc("st3",   0,1,0,0,0, 0,0,0,   0,0,3, 1,0,0);
        cyc("tk3a",  0,0,0,0,1, 0,0,0,   0,0,2, 1,0,0);
        cyc("tk3b",  0,0,0,0,1, 0,0,0,   0,0,1, 1,0,0);
        cyc("tk3c",  0,0,0,0,1, 0,0,0,   0,0,0, 0,1,1);
        idle("post_exp", 0,0,0, 0,1);
        cyc("st_exp", 0,1,0,0,0, 0,0,0,  0,0,0, 0,0,1);
        for (int i = 1; i < 10; i++)
            cyc("alarm_win", 0,0,0,0,1, 0,0,0, 0,0,0, 0,0,1);
        cyc("alarm_end", 0,0,0,0,1, 0,0,0, 0,0,0, 0,0,0);
        cyc("st_idle",  0,1,0,0,0, 0,0,0, 0,0,0, 0,0,0);
        cyc("ld_zero",  1,0,0,0,0, 0,0,0, 0,0,0, 0,0,0);
        cyc("st_zero",  0,1,0,0,0, 0,0,0, 0,0,0, 0,0,0);

        // double borrow
        cyc("ld1h",  1,0,0,0,0, 1,0,0,   1,0,0,   0,0,0);
        cyc("st1h",  0,1,0,0,0, 0,0,0,   1,0,0,   1,0,0);
        cyc("tk1h",  0,0,0,0,1, 0,0,0,   0,59,59, 1,0,0);
        cyc("tk1h2", 0,0,0,0,1, 0,0,0,   0,59,58, 1,0,0);
        cyc("clr1h", 0,0,0,1,0, 0,0,0,   0,0,0,   0,0,0);

        // clamping
        cyc("ldclamp", 1,0,0,0,0, 99,75,80, 23,59,59, 0,0,0);
        cyc("stclamp", 0,1,0,0,0, 0,0,0,    23,59,59, 1,0,0);
        cyc("clrclamp",0,0,0,1,0, 0,0,0,    0,0,0,    0,0,0);

        // pause drops a coincident tick
        cyc("ld10",   1,0,0,0,0, 0,0,10, 0,0,10, 0,0,0);
        cyc("st10",   0,1,0,0,0, 0,0,0,  0,0,10, 1,0,0);
        cyc("pstk",   0,0,1,0,1, 0,0,0,  0,0,10, 0,0,0);
        cyc("tk_pse", 0,0,0,0,1, 0,0,0,  0,0,10, 0,0,0);
        cyc("resume", 0,1,0,0,0, 0,0,0,  0,0,10, 1,0,0);
        cyc("tk9",    0,0,0,0,1, 0,0,0,  0,0,9,  1,0,0);
        cyc("ld_run", 1,0,0,0,0, 0,0,5,  0,0,9,  1,0,0);
        cyc("clr10",  0,0,0,1,0, 0,0,0,  0,0,0,  0,0,0);

        // async reset mid-run
        cyc("ld1234", 1,0,0,0,0, 0,12,34, 0,12,34, 0,0,0);
        cyc("st1234", 0,1,0,0,0, 0,0,0,   0,12,34, 1,0,0);
        cyc("tk1233", 0,0,0,0,1, 0,0,0,   0,12,33, 1,0,0);
        #1 rst_n = 1'b0;
        #1 chk_zero("async_rst");
        @(negedge CLK);
        rst_n = 1'b1;
        @(posedge CLK); #1;

        // clear during EXPIRED, then load in EXPIRED
        cyc("ld1a",   1,0,0,0,0, 0,0,1, 0,0,1, 0,0,0);
        cyc("st1a",   0,1,0,0,0, 0,0,0, 0,0,1, 1,0,0);
        cyc("exp1a",  0,0,0,0,1, 0,0,0, 0,0,0, 0,1,1);
        cyc("clr_exp",0,0,0,1,0, 0,0,0, 0,0,0, 0,0,0);
        cyc("ld1b",   1,0,0,0,0, 0,0,1, 0,0,1, 0,0,0);
        cyc("st1b",   0,1,0,0,0, 0,0,0, 0,0,1, 1,0,0);
        cyc("exp1b",  0,0,0,0,1, 0,0,0, 0,0,0, 0,1,1);
        cyc("ld_exp", 1,0,0,0,0, 0,1,0, 0,1,0, 0,0,0);
        cyc("st_m",   0,1,0,0,0, 0,0,0, 0,1,0, 1,0,0);
        cyc("tk_m",   0,0,0,0,1, 0,0,0, 0,0,59,1,0,0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
